// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch stage feeding IF/ID. Owns the PC, issues single-outstanding
//            instruction-memory reads, buffers one response across stalls and
//            drains stale responses after branch redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        fetch_valid
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] instr_q, instr_d;
   logic        fetch_valid_q, fetch_valid_d;
   // Set during reset so the request stays low while rst is asserted; kept
   // registered so imem_req has no combinational path from any input.
   logic        req_block_q;
   logic        req_issue;

   // A request is actually on the bus only in REQ once reset has been released.
   assign req_issue   = (state_q == ST_REQ) && !req_block_q;
   assign imem_req    = req_issue;
   assign imem_addr   = fetch_pc_q;
   assign pc_out      = pc_out_q;
   assign instruction = instr_q;
   assign fetch_valid = fetch_valid_q;

   // Next-state and output-register logic; redirect overrides everything else.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      pc_out_d     = pc_out_q;
      if (stall) begin
         instr_d       = instr_q;
         fetch_valid_d = fetch_valid_q;
      end else begin
         instr_d       = NOP_INSTR;
         fetch_valid_d = 1'b0;
      end

      if (redirect_valid) begin
         fetch_pc_d    = redirect_pc;
         instr_d       = NOP_INSTR;
         fetch_valid_d = 1'b0;
         case (state_q)
            ST_REQ:   state_d = req_issue ? ST_DRAIN : ST_REQ;
            ST_WAIT:  state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
            ST_HOLD:  state_d = ST_REQ;
            ST_DRAIN: state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
            default:  state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (req_issue) begin
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (stall) begin
                     hold_pc_d    = fetch_pc_q;
                     hold_instr_d = imem_rdata;
                     state_d      = ST_HOLD;
                  end else begin
                     pc_out_d      = fetch_pc_q;
                     instr_d       = imem_rdata;
                     fetch_valid_d = 1'b1;
                     fetch_pc_d    = fetch_pc_q + PC_STEP;
                     state_d       = ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc_out_d      = hold_pc_q;
                  instr_d       = hold_instr_q;
                  fetch_valid_d = 1'b1;
                  fetch_pc_d    = fetch_pc_q + PC_STEP;
                  state_d       = ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (imem_rvalid) begin
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_REQ;
         fetch_pc_q    <= RESET_PC;
         hold_pc_q     <= 32'h0;
         hold_instr_q  <= NOP_INSTR;
         pc_out_q      <= 32'h0;
         instr_q       <= NOP_INSTR;
         fetch_valid_q <= 1'b0;
         req_block_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         hold_pc_q     <= hold_pc_d;
         hold_instr_q  <= hold_instr_d;
         pc_out_q      <= pc_out_d;
         instr_q       <= instr_d;
         fetch_valid_q <= fetch_valid_d;
         req_block_q   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-stage producer feeding the IF/ID pipeline register. It owns the program counter, issues one-outstanding read requests to instruction memory over a request/response handshake, and presents `pc_out`/`instruction` to IF/ID. It supports hazard-unit stalls through a one-entry hold buffer and branch redirects with bubble insertion. On a redirect it discards any in-flight memory response.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `PC_STEP`, 4, sequential PC increment in bytes.
- `NOP_INSTR`, 32'h0000_0000, bubble word driven on `instruction` when no valid instruction is present.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset; sampled on posedge `clk`.
- `stall`  in  1  hazard unit: IF/ID must not advance; hold outputs.
- `redirect_valid`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  read request, one-cycle pulse.
- `imem_addr`  out  32  read address, valid while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid, one-cycle pulse, at least 1 cycle after the request.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `pc_out`  out  32  PC of the presented instruction.
- `instruction`  out  32  instruction presented to IF/ID.
- `fetch_valid`  out  1  `instruction` is a real fetched word, not a bubble.

## Operation
- Registers: `state`, `fetch_pc`, hold buffer (`hold_pc`, `hold_instr`), and registered outputs.
- States:
  - REQ: drive `imem_req`=1 with `imem_addr`=`fetch_pc`, then go to WAIT.
  - WAIT: wait for `imem_rvalid`.
  - HOLD: response captured while `stall`=1.
  - DRAIN: redirect occurred while a response was outstanding; discard the next `imem_rvalid`, then go to REQ.
- WAIT with `imem_rvalid`=1 and `stall`=0:
  - `pc_out`<=`fetch_pc`, `instruction`<=`imem_rdata`, `fetch_valid`<=1.
  - `fetch_pc`<=`fetch_pc`+`PC_STEP`, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0).
  - Go to REQ.
- WAIT with `imem_rvalid`=1 and `stall`=1: `hold_pc`<=`fetch_pc`, `hold_instr`<=`imem_rdata`, go to HOLD; outputs unchanged.
- HOLD with `stall`=0: load outputs from the hold buffer, `fetch_valid`<=1, advance `fetch_pc`, go to REQ.
- Output rules:
  - Any cycle with `stall`=1 and no redirect: `pc_out`, `instruction`, `fetch_valid` hold their values.
  - Any cycle with `stall`=0, no redirect and no new load: `instruction`<=`NOP_INSTR`, `fetch_valid`<=0, `pc_out` holds.
  - Each fetched word is therefore presented unstalled for exactly one cycle.
- Redirect: highest priority, overrides `stall`. On a cycle with `redirect_valid`=1:
  - `fetch_pc`<=`redirect_pc`, `instruction`<=`NOP_INSTR`, `fetch_valid`<=0; hold buffer invalidated.
  - From REQ: the request issued this cycle is outstanding, go to DRAIN.
  - From WAIT without `imem_rvalid`: go to DRAIN.
  - From WAIT with `imem_rvalid`, from HOLD, or from DRAIN with `imem_rvalid`: go to REQ; the arriving data is discarded.
  - From DRAIN without `imem_rvalid`: stay in DRAIN.
- `imem_rvalid` in REQ or HOLD is a protocol violation; it is ignored.
- At most one request is ever outstanding.

## Timing
- Reset (`rst`=0 at posedge):
  - `state`=REQ, `fetch_pc`=`RESET_PC`.
  - `pc_out`=0, `instruction`=`NOP_INSTR`, `fetch_valid`=0.
  - `imem_req`=0 (forced low while `rst`=0), `imem_addr`=`RESET_PC`.
  - Reset mid-transaction abandons the outstanding request; a late `imem_rvalid` after reset is accepted as the response to the new request only if it arrives in WAIT.
- First cycle after `rst` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Latency: data sampled with `imem_rvalid` at edge N appears on outputs after edge N. With a 1-cycle memory, throughput is one instruction per 2 cycles.
- Redirect effect is visible on outputs after the same edge. The first request to the target issues 1 cycle later from REQ, or after the drained response from DRAIN.
- `imem_req` and `imem_addr` are decoded from registered state only; no combinational path from inputs.

## Test plan
- Reset/start: hold `rst`=0 for 3 cycles, release, 1-cycle memory returning `addr^32'hA5A5_0000` -> `imem_req` pulses at addrs 0,4,8; outputs (0,32'hA5A5_0000), (4,32'hA5A5_0004), each with `fetch_valid`=1 for one cycle, NOP/0 between.
- Stall on response: `stall`=1 in the cycle `imem_rvalid` returns addr 8 data, held for 3 cycles -> no new `imem_req`; data appears on the cycle after `stall` falls; next request addr 12.
- Redirect while waiting: memory latency 3, `redirect_valid`=1 with `redirect_pc`=32'h100 one cycle after request to addr 4 -> addr-4 data is never presented; next `imem_req` at 32'h100 after the drained `imem_rvalid`.
- Redirect during stall: in HOLD with `stall`=1, `redirect_valid`=1, `redirect_pc`=32'h40 -> `fetch_valid`=0, `instruction`=`NOP_INSTR` next cycle; request at 32'h40 follows.
- Wrap: redirect to 32'hFFFF_FFFC -> `pc_out`=32'hFFFF_FFFC presented, next `imem_addr`=0.
- Reset mid-WAIT: `rst`=0 while a request is outstanding -> all outputs at reset values next cycle; after release, the first request is at `RESET_PC`.
